// File: rtl/frame_buffer_writer_pkg.sv
// Shared definitions for the frame buffer writer and the VGA read side:
// command encodings, default frame size and the {Y, X} address map.
package frame_buffer_writer_pkg;

  localparam int H_PIX_DEF = 160;
  localparam int V_PIX_DEF = 120;
  localparam int X_W       = 8;
  localparam int Y_W       = 7;
  localparam int ADDR_W    = Y_W + X_W;

  typedef enum logic [1:0] {
    OP_SET_PIXEL  = 2'b00,
    OP_FILL_RECT  = 2'b01,
    OP_CLEAR      = 2'b10,
    OP_WAIT_VSYNC = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAW,
    ST_WAIT_VS,
    ST_FINISH
  } state_t;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [Y_W-1:0] y,
                                                  input logic [X_W-1:0] x);
    return {y, x};
  endfunction

endpackage

// File: rtl/frame_buffer_writer_if.sv
// Command and frame-buffer write bus of the frame buffer writer.
// master = command issuer / buffer observer, slave = the writer itself.
interface frame_buffer_writer_if;
  import frame_buffer_writer_pkg::*;

  logic              CMD_VALID;
  logic              CMD_READY;
  logic [1:0]        CMD_OP;
  logic [X_W-1:0]    CMD_X0;
  logic [X_W-1:0]    CMD_X1;
  logic [Y_W-1:0]    CMD_Y0;
  logic [Y_W-1:0]    CMD_Y1;
  logic              CMD_COLOUR;
  logic              BUF_WE;
  logic [ADDR_W-1:0] BUF_ADDR;
  logic              BUF_DATA;

  modport master (
    output CMD_VALID, CMD_OP, CMD_X0, CMD_X1, CMD_Y0, CMD_Y1, CMD_COLOUR,
    input  CMD_READY, BUF_WE, BUF_ADDR, BUF_DATA
  );

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_X0, CMD_X1, CMD_Y0, CMD_Y1, CMD_COLOUR,
    output CMD_READY, BUF_WE, BUF_ADDR, BUF_DATA
  );

endinterface

// File: rtl/frame_buffer_writer_sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level plus a falling-edge
// detector on the synchronized value. Flops reset high (idle sync level).
module sync_edge_detect (
  input  logic CLK,
  input  logic RESET,
  input  logic async_in,
  output logic sync_out,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_out = sync_q;
  assign fall     = prev_q & ~sync_q;

endmodule

// File: rtl/frame_buffer_writer.sv
// Frame buffer writer: accepts pixel/rectangle/clear/vsync-wait commands
// and streams one pixel write per cycle in raster order.
//   state      | meaning
//   ST_IDLE    | ready for a command
//   ST_DRAW    | writing one pixel per cycle
//   ST_WAIT_VS | waiting for falling edge of synchronized VGA_VS
//   ST_FINISH  | one-cycle DONE pulse
module frame_buffer_writer
  import frame_buffer_writer_pkg::*;
#(
  parameter int H_PIX = H_PIX_DEF,
  parameter int V_PIX = V_PIX_DEF
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        VGA_VS,
  frame_buffer_writer_if.slave        cmd_bus,
  output logic                        BUSY,
  output logic                        DONE
);

  localparam logic [X_W-1:0] X_MAX = X_W'(H_PIX - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_PIX - 1);

  state_t         state, state_nxt;
  logic [X_W-1:0] x_cnt, x_start, x_end;
  logic [Y_W-1:0] y_cnt, y_end;
  logic           colour;

  logic [X_W-1:0] dec_x0, dec_x1, x1_clamp;
  logic [Y_W-1:0] dec_y0, dec_y1, y1_clamp;
  logic           rect_empty;
  logic           is_wait;
  logic           accept;
  logic           last_pix;
  logic           vs_sync, vs_fall;
  logic           ready, we, busy, done;

  sync_edge_detect u_vs_sync (
    .CLK      (CLK),
    .RESET    (RESET),
    .async_in (VGA_VS),
    .sync_out (vs_sync),
    .fall     (vs_fall)
  );

  // Every op is normalised to an inclusive, clamped rectangle.
  always_comb begin
    dec_x0  = cmd_bus.CMD_X0;
    dec_x1  = cmd_bus.CMD_X1;
    dec_y0  = cmd_bus.CMD_Y0;
    dec_y1  = cmd_bus.CMD_Y1;
    is_wait = 1'b0;
    case (op_t'(cmd_bus.CMD_OP))
      OP_SET_PIXEL: begin
        dec_x1 = cmd_bus.CMD_X0;
        dec_y1 = cmd_bus.CMD_Y0;
      end
      OP_CLEAR: begin
        dec_x0 = '0;
        dec_x1 = X_MAX;
        dec_y0 = '0;
        dec_y1 = Y_MAX;
      end
      OP_WAIT_VSYNC: is_wait = 1'b1;
      default: ;
    endcase
    x1_clamp   = (dec_x1 > X_MAX) ? X_MAX : dec_x1;
    y1_clamp   = (dec_y1 > Y_MAX) ? Y_MAX : dec_y1;
    rect_empty = (dec_x0 > X_MAX) || (dec_y0 > Y_MAX) ||
                 (dec_x0 > x1_clamp) || (dec_y0 > y1_clamp);
  end

  assign last_pix = (x_cnt == x_end) && (y_cnt == y_end);
  assign accept   = ready & cmd_bus.CMD_VALID;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    we        = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (cmd_bus.CMD_VALID) begin
          if (is_wait)         state_nxt = ST_WAIT_VS;
          else if (rect_empty) state_nxt = ST_FINISH;
          else                 state_nxt = ST_DRAW;
        end
      end
      ST_DRAW: begin
        we = 1'b1;
        if (last_pix) state_nxt = ST_FINISH;
      end
      ST_WAIT_VS: begin
        if (vs_fall) state_nxt = ST_FINISH;
      end
      ST_FINISH: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      x_start <= '0;
      x_end   <= '0;
      y_end   <= '0;
      colour  <= 1'b0;
    end else if (accept) begin
      x_cnt   <= dec_x0;
      y_cnt   <= dec_y0;
      x_start <= dec_x0;
      x_end   <= x1_clamp;
      y_end   <= y1_clamp;
      colour  <= cmd_bus.CMD_COLOUR;
    end else if (state == ST_DRAW && !last_pix) begin
      if (x_cnt == x_end) begin
        x_cnt <= x_start;
        y_cnt <= y_cnt + 1'b1;
      end else begin
        x_cnt <= x_cnt + 1'b1;
      end
    end
  end

  assign cmd_bus.CMD_READY = ready;
  assign cmd_bus.BUF_WE    = we;
  assign cmd_bus.BUF_ADDR  = pack_addr(y_cnt, x_cnt);
  assign cmd_bus.BUF_DATA  = colour;
  assign BUSY              = busy;
  assign DONE              = done;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Scoreboard bench for frame_buffer_writer: directed commands push expected
// writes/DONE cycles; a negedge monitor pops and compares.
module tb_frame_buffer_writer;
  import frame_buffer_writer_pkg::*;

  typedef struct {
    logic [14:0] addr;
    logic        data;
    int          cyc;
  } wr_t;

  logic CLK = 1'b0;
  logic RESET;
  logic VGA_VS;
  logic BUSY;
  logic DONE;
  int   cyc = 0;
  int   assertions = 0;
  int   failures = 0;

  wr_t  wr_q[$];
  int   done_q[$];

  frame_buffer_writer_if bus ();

  frame_buffer_writer #(.H_PIX(160), .V_PIX(120)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .VGA_VS  (VGA_VS),
    .cmd_bus (bus),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin : monitor
    wr_t w;
    if (bus.BUF_WE === 1'b1) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_write", {17'd0, bus.BUF_ADDR}, 32'hFFFF_FFFF);
      end else begin
        w = wr_q.pop_front();
        chk("wr_addr", {17'd0, bus.BUF_ADDR}, {17'd0, w.addr});
        chk("wr_data", {31'd0, bus.BUF_DATA}, {31'd0, w.data});
        chk("wr_cycle", cyc, w.cyc);
      end
    end
    if (DONE === 1'b1) begin
      if (done_q.size() == 0) chk("unexpected_done", cyc, 32'hFFFF_FFFF);
      else chk("done_cycle", cyc, done_q.pop_front());
    end
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] x0, input logic [7:0] x1,
                       input logic [6:0] y0, input logic [6:0] y1, input logic col,
                       output int acc);
    int n = 0;
    @(negedge CLK);
    while (bus.CMD_READY !== 1'b1 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) chk("ready_timeout", n, 0);
    bus.CMD_OP     = op;
    bus.CMD_X0     = x0;
    bus.CMD_X1     = x1;
    bus.CMD_Y0     = y0;
    bus.CMD_Y1     = y1;
    bus.CMD_COLOUR = col;
    bus.CMD_VALID  = 1'b1;
    acc = cyc;
    @(posedge CLK);
    #1;
    // Scramble fields after acceptance; the command must not notice.
    bus.CMD_VALID  = 1'b0;
    bus.CMD_OP     = 2'b01;
    bus.CMD_X0     = 8'h00;
    bus.CMD_X1     = 8'hFF;
    bus.CMD_Y0     = 7'h00;
    bus.CMD_Y1     = 7'h7F;
    bus.CMD_COLOUR = ~col;
  endtask

  task automatic expect_rect(input int acc, input int ex0, input int ex1,
                             input int ey0, input int ey1, input logic col);
    int k = 0;
    for (int y = ey0; y <= ey1; y++) begin
      for (int x = ex0; x <= ex1; x++) begin
        wr_q.push_back('{addr: 15'((y << 8) | x), data: col, cyc: acc + 1 + k});
        k++;
      end
    end
    done_q.push_back(acc + 1 + k);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((wr_q.size() != 0 || done_q.size() != 0) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    @(negedge CLK);
    chk("drain_writes", wr_q.size(), 0);
    chk("drain_done", done_q.size(), 0);
  endtask

  initial begin
    int acc;
    int bad;
    int f;
    int n;
    RESET          = 1'b1;
    VGA_VS         = 1'b1;
    bus.CMD_VALID  = 1'b0;
    bus.CMD_OP     = 2'b00;
    bus.CMD_X0     = '0;
    bus.CMD_X1     = '0;
    bus.CMD_Y0     = '0;
    bus.CMD_Y1     = '0;
    bus.CMD_COLOUR = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ready", {31'd0, bus.CMD_READY}, 1);
    chk("rst_busy", {31'd0, BUSY}, 0);
    chk("rst_done", {31'd0, DONE}, 0);
    chk("rst_we", {31'd0, bus.BUF_WE}, 0);
    chk("rst_addr", {17'd0, bus.BUF_ADDR}, 0);
    chk("rst_data", {31'd0, bus.BUF_DATA}, 0);
    RESET = 1'b0;

    // SET_PIXEL (5,3) -> 0x0305
    issue(2'b00, 8'd5, 8'd99, 7'd3, 7'd99, 1'b1, acc);
    wr_q.push_back('{addr: 15'h0305, data: 1'b1, cyc: acc + 1});
    done_q.push_back(acc + 2);
    wait_idle(50);

    // FILL_RECT (2,1)-(4,2)
    issue(2'b01, 8'd2, 8'd4, 7'd1, 7'd2, 1'b1, acc);
    expect_rect(acc, 2, 4, 1, 2, 1'b1);
    wait_idle(50);

    // Empty rectangles: X0 off-screen, then X0 > X1
    issue(2'b01, 8'd200, 8'd210, 7'd0, 7'd0, 1'b1, acc);
    done_q.push_back(acc + 1);
    wait_idle(50);
    issue(2'b01, 8'd10, 8'd5, 7'd0, 7'd3, 1'b1, acc);
    done_q.push_back(acc + 1);
    wait_idle(50);

    // X1=255 clamps to 159; Y1=127 clamps to 119
    issue(2'b01, 8'd157, 8'd255, 7'd10, 7'd11, 1'b1, acc);
    expect_rect(acc, 157, 159, 10, 11, 1'b1);
    wait_idle(50);
    issue(2'b01, 8'd3, 8'd3, 7'd118, 7'd127, 1'b0, acc);
    expect_rect(acc, 3, 3, 118, 119, 1'b0);
    wait_idle(50);

    // CLEAR colour 0: 19200 writes, last 0x779F, DONE at acc+19201
    issue(2'b10, 8'd50, 8'd60, 7'd5, 7'd6, 1'b0, acc);
    expect_rect(acc, 0, 159, 0, 119, 1'b0);
    chk("clear_last_addr", {17'd0, wr_q[$].addr}, 32'h779F);
    chk("clear_done_cyc", done_q[$] - acc, 19201);
    bad = 0;
    repeat (19201) begin
      @(negedge CLK);
      if (BUSY !== 1'b1) bad++;
    end
    chk("clear_busy_low_cycles", bad, 0);
    wait_idle(100);
    chk("clear_ready_after", {31'd0, bus.CMD_READY}, 1);

    // WAIT_VSYNC: VS high 1000 cycles, then low
    issue(2'b11, 8'd1, 8'd2, 7'd1, 7'd2, 1'b1, acc);
    bad = 0;
    repeat (1000) begin
      @(negedge CLK);
      if (BUSY !== 1'b1) bad++;
    end
    chk("vs_busy_low_cycles", bad, 0);
    f = cyc;
    VGA_VS = 1'b0;
    done_q.push_back(f + 3);
    wait_idle(50);
    VGA_VS = 1'b1;
    repeat (5) @(negedge CLK);

    // RESET at write 50 of a CLEAR, then a normal SET_PIXEL
    issue(2'b10, 8'd0, 8'd0, 7'd0, 7'd0, 1'b1, acc);
    for (int k = 0; k < 50; k++)
      wr_q.push_back('{addr: 15'(k), data: 1'b1, cyc: acc + 1 + k});
    n = 0;
    while (cyc != acc + 50 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("abort_reach_write50", cyc, acc + 50);
    RESET = 1'b1;
    @(negedge CLK);
    chk("abort_we", {31'd0, bus.BUF_WE}, 0);
    chk("abort_done", {31'd0, DONE}, 0);
    chk("abort_ready", {31'd0, bus.CMD_READY}, 1);
    chk("abort_busy", {31'd0, BUSY}, 0);
    RESET = 1'b0;
    repeat (10) @(negedge CLK);
    chk("abort_writes_left", wr_q.size(), 0);
    issue(2'b00, 8'd7, 8'd0, 7'd9, 7'd0, 1'b1, acc);
    wr_q.push_back('{addr: 15'h0907, data: 1'b1, cyc: acc + 1});
    done_q.push_back(acc + 2);
    wait_idle(50);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/frame_buffer_writer.md
FRAME_BUFFER_WRITER -- requirements
Module: frame_buffer_writer

Interface
REQ-001 SHALL have parameter H_PIX, default 160, meaning frame buffer width in pixels.
REQ-002 SHALL have parameter V_PIX, default 120, meaning frame buffer height in pixels.
REQ-003 SHALL have port CLK  input  1  system clock (100 MHz); the only clock; all logic on posedge CLK.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port CMD_VALID  input  1  command present.
REQ-006 SHALL have port CMD_READY  output  1  block accepts a command this cycle.
REQ-007 SHALL have port CMD_OP  input  2  operation: 00 SET_PIXEL, 01 FILL_RECT, 10 CLEAR, 11 WAIT_VSYNC.
REQ-008 SHALL have ports CMD_X0 and CMD_X1  input  8 each  column bounds.
REQ-009 SHALL have ports CMD_Y0 and CMD_Y1  input  7 each  row bounds.
REQ-010 SHALL have port CMD_COLOUR  input  1  pixel value to write (1 foreground, 0 background).
REQ-011 SHALL have port VGA_VS  input  1  vertical sync from the VGA generator; active low; asynchronous to CLK.
REQ-012 SHALL have port BUF_WE  output  1  frame buffer write enable.
REQ-013 SHALL have port BUF_ADDR  output  15  write address {Y[6:0], X[7:0]}, matching the VGA read-side address map.
REQ-014 SHALL have port BUF_DATA  output  1  write data.
REQ-015 SHALL have port BUSY  output  1  high in any state other than IDLE.
REQ-016 SHALL have port DONE  output  1  one-cycle pulse when a command completes.

Function
REQ-017 SHALL implement an FSM with states IDLE, DRAW, WAIT_VS and FINISH.
REQ-018 SHALL assert CMD_READY only in IDLE; a command is accepted on a cycle with CMD_VALID and CMD_READY both high.
REQ-019 SHALL register all CMD_* fields on acceptance; later input changes have no effect until DONE.
REQ-020 SHALL, for SET_PIXEL, treat the command as FILL_RECT with X1=X0 and Y1=Y0.
REQ-021 SHALL, for CLEAR, treat the command as FILL_RECT over 0..H_PIX-1 by 0..V_PIX-1.
REQ-022 SHALL, for FILL_RECT, clamp X1 to H_PIX-1 and Y1 to V_PIX-1.
REQ-023 SHALL, for FILL_RECT, write one pixel per cycle in raster order (x inner, y outer) from (X0,Y0) to clamped (X1,Y1) inclusive.
REQ-024 SHALL drive BUF_WE high in the first write cycle, which is the cycle after acceptance, and keep it high continuously until the last pixel; BUF_DATA equals the registered CMD_COLOUR throughout.
REQ-025 SHALL treat a rectangle as empty when X0>X1, Y0>Y1, X0>=H_PIX or Y0>=V_PIX; an empty rectangle performs zero writes and goes directly to FINISH.
REQ-026 SHALL, for WAIT_VSYNC, pass VGA_VS through a 2-flop synchronizer and remain in WAIT_VS until a falling edge of the synchronized signal, then go to FINISH.
REQ-027 SHALL spend exactly one cycle in FINISH with DONE=1, then return to IDLE with CMD_READY=1.
REQ-028 SHALL give a write command of N pixels a total duration of acceptance + N write cycles + 1 FINISH cycle; a CLEAR therefore takes 19200 writes.
REQ-029 SHALL hold BUF_WE=0 in IDLE, WAIT_VS and FINISH; BUF_ADDR and BUF_DATA are don't-care when BUF_WE=0.
REQ-030 SHALL size the x counter at 8 bits and the y counter at 7 bits; the x counter reloads X0 at row end, and no counter wraps past H_PIX-1 or V_PIX-1.

Reset
REQ-031 SHALL, on RESET high at a clock edge, force from the next cycle: state IDLE, BUF_WE=0, BUF_ADDR=0, BUF_DATA=0, DONE=0, BUSY=0, CMD_READY=1, and synchronizer flops=1.
REQ-032 SHALL abort any command in progress when RESET is asserted mid-operation, with no further writes and no DONE pulse.

Structure
REQ-033 SHALL place the op encodings, H_PIX/V_PIX defaults and the address-packing widths (7-bit Y, 8-bit X) in a shared package used by both the writer and the VGA generator.
REQ-034 SHALL implement the VGA_VS synchronizer and falling-edge detector as one sub-module, sync_edge_detect; all other logic is flat.

Verification
REQ-035 SHALL verify: SET_PIXEL (X0=5, Y0=3, colour 1) -> a single write at address 0x0305 with data 1 one cycle after acceptance, and DONE on the following cycle.
REQ-036 SHALL verify: FILL_RECT (2,1)-(4,2) -> 6 consecutive writes at 0x0102, 0x0103, 0x0104, 0x0202, 0x0203, 0x0204.
REQ-037 SHALL verify: CLEAR with colour 0 -> 19200 writes, last address 0x779F, BUSY high throughout, DONE at cycle 19201 after acceptance.
REQ-038 SHALL verify: FILL_RECT X0=200, or X0=10 with X1=5 -> zero writes and DONE one cycle after acceptance; FILL_RECT X1=255 -> writes clamped to x=159.
REQ-039 SHALL verify: WAIT_VSYNC with VGA_VS held high for 1000 cycles, then driven low -> DONE 3-4 cycles after the falling edge and no writes.
REQ-040 SHALL verify: RESET asserted at write 50 of a CLEAR -> BUF_WE=0 from the next cycle, no DONE pulse, CMD_READY=1, and a subsequent SET_PIXEL executes normally.
